// File: rtl/lamp_switch_sequencer_pkg.sv
// lamp_pkg
//  Shared definitions for the staircase lamp controller:
//   - active-low 7-segment codes SEG_0..SEG_7, bit order {g,f,e,d,c,b,a}
//   - buzzer FSM state encoding
//   - seg_decode(): switch code {S3,S2,S1} to segment pattern
package lamp_pkg;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;

    typedef enum logic {
        IDLE = 1'b0,
        BEEP = 1'b1
    } buz_state_t;

    function automatic logic [6:0] seg_decode(input logic [2:0] code);
        logic [6:0] seg;
        case (code)
            3'd0:    seg = SEG_0;
            3'd1:    seg = SEG_1;
            3'd2:    seg = SEG_2;
            3'd3:    seg = SEG_3;
            3'd4:    seg = SEG_4;
            3'd5:    seg = SEG_5;
            3'd6:    seg = SEG_6;
            default: seg = SEG_7;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/lamp_switch_sequencer_if.sv
// lamp_switch_sequencer_if
//  Board-side pin bundle of the staircase lamp controller.
//   S1..S3  raw switches (board -> controller)
//   F       lamp drive
//   Buzzer  buzzer drive
//   LED     7-segment pattern {g,f,e,d,c,b,a}, active-low
//  master: the board/switch side, slave: the controller.
interface lamp_switch_sequencer_if;

    logic       S1;
    logic       S2;
    logic       S3;
    logic       F;
    logic       Buzzer;
    logic [6:0] LED;

    modport master (
        output S1, S2, S3,
        input  F, Buzzer, LED
    );

    modport slave (
        input  S1, S2, S3,
        output F, Buzzer, LED
    );

endinterface

// File: rtl/lamp_switch_sequencer_sw_debounce.sv
// sw_debounce
//  One-bit switch conditioner: 2-FF synchroniser followed by a stability
//  counter. The debounced output only follows the synchronised input after
//  it has differed from the current debounced value for DEB_CYCLES
//  consecutive cycles; shorter glitches are dropped.
// Ports
//  clk  in   system clock, rising edge
//  rst  in   asynchronous active-high reset
//  raw  in   raw, asynchronous, bouncy switch
//  deb  out  debounced level, registered
module sw_debounce #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned CW         = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic deb
);

    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    // The counter restarts whenever the synchronised input agrees with the
    // debounced level, so only an uninterrupted run of differing cycles
    // gets through. It never exceeds DEB_LAST.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            deb <= 1'b0;
        end else if (sync_b != deb) begin
            if (cnt == DEB_LAST) begin
                deb <= sync_b;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/lamp_switch_sequencer.sv
// lamp_switch_sequencer
//  Three-switch staircase lamp controller. Each raw switch is synchronised
//  and debounced; every accepted switch change toggles the lamp by the
//  parity of the changed bits, starts (or restarts) a buzzer beep, and an
//  idle lit lamp is switched off after AUTO_OFF cycles (0 disables this).
//  The 7-segment digit shows the debounced switch code {S3,S2,S1}.
// Ports
//  clk         in   system clock, rising edge
//  rst         in   asynchronous active-high reset
//  bus.S1..S3  in   raw switches
//  bus.F       out  lamp drive, registered
//  bus.Buzzer  out  buzzer drive, registered (high exactly while in BEEP)
//  bus.LED     out  active-low segment pattern, registered
module lamp_switch_sequencer
    import lamp_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned BUZ_CYCLES = 8,
    parameter int unsigned AUTO_OFF   = 64,
    parameter int unsigned CW         = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    lamp_switch_sequencer_if.slave  bus
);

    localparam bit              AUTO_EN   = (AUTO_OFF > 0);
    localparam logic [CW-1:0]   BUZ_LAST  = CW'(BUZ_CYCLES - 1);
    localparam logic [CW-1:0]   IDLE_LAST = CW'(AUTO_EN ? AUTO_OFF - 1 : 0);

    logic [2:0]    raw_sw;
    logic [2:0]    deb;
    logic [2:0]    deb_prev;
    logic [2:0]    chg;
    logic          ev;
    logic          off_ev;
    logic          f_q;
    logic          buz_q;
    logic [6:0]    led_q;
    logic [CW-1:0] idle_cnt;
    logic [CW-1:0] bcnt;
    buz_state_t    state;

    assign raw_sw = {bus.S3, bus.S2, bus.S1};

    for (genvar i = 0; i < 3; i++) begin : g_deb
        sw_debounce #(
            .DEB_CYCLES (DEB_CYCLES),
            .CW         (CW)
        ) u_deb (
            .clk (clk),
            .rst (rst),
            .raw (raw_sw[i]),
            .deb (deb[i])
        );
    end

    assign chg = deb ^ deb_prev;
    assign ev  = |chg;

    // Auto-off fires only on a quiet cycle; a switch event in the same
    // cycle takes priority and restarts the idle count instead.
    assign off_ev = AUTO_EN && f_q && !ev && (idle_cnt == IDLE_LAST);

    // Lamp register and idle timer. Toggling by the parity of the changed
    // bits keeps F equal to S1^S2^S3 when two switches move together,
    // until an auto-off breaks that relationship.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_prev <= 3'b000;
            f_q      <= 1'b0;
            idle_cnt <= '0;
        end else begin
            deb_prev <= deb;
            if (ev) begin
                f_q      <= f_q ^ (^chg);
                idle_cnt <= '0;
            end else if (!f_q) begin
                idle_cnt <= '0;
            end else if (off_ev) begin
                f_q      <= 1'b0;
                idle_cnt <= '0;
            end else if (AUTO_EN) begin
                idle_cnt <= idle_cnt + CW'(1);
            end
        end
    end

    // Buzzer FSM. Any event while beeping restarts the full beep length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            bcnt  <= '0;
            buz_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ev || off_ev) begin
                        state <= BEEP;
                        bcnt  <= '0;
                        buz_q <= 1'b1;
                    end
                end
                BEEP: begin
                    if (ev || off_ev) begin
                        bcnt <= '0;
                    end else if (bcnt == BUZ_LAST) begin
                        state <= IDLE;
                        bcnt  <= '0;
                        buz_q <= 1'b0;
                    end else begin
                        bcnt <= bcnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    bcnt  <= '0;
                    buz_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q <= SEG_0;
        end else begin
            led_q <= seg_decode(deb);
        end
    end

    assign bus.F      = f_q;
    assign bus.Buzzer = buz_q;
    assign bus.LED    = led_q;

endmodule

// File: tb/tb_lamp_switch_sequencer.sv
// tb_lamp_switch_sequencer
//  Self-checking bench for lamp_switch_sequencer with DEB_CYCLES=4,
//  BUZ_CYCLES=8, AUTO_OFF=64. Inputs change 1 time unit after a rising
//  edge and outputs are sampled at the same point; "edge N" below counts
//  rising edges after the input change (cyc).
module tb_lamp_switch_sequencer;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;

    typedef struct {
        logic [2:0] sw;
        int         hold;
        logic       exp_f;
        logic [6:0] exp_led;
    } vec_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    vec_t vecs[8];

    lamp_switch_sequencer_if bus ();

    lamp_switch_sequencer #(
        .DEB_CYCLES (4),
        .BUZ_CYCLES (8),
        .AUTO_OFF   (64),
        .CW         (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [2:0] sw);
        bus.S3 = sw[2];
        bus.S2 = sw[1];
        bus.S1 = sw[0];
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic stepTo(input int target);
        while (cyc < target) stepCycle();
    endtask

    // Three comparisons per call: lamp, buzzer and segment pattern.
    task automatic checkOutput(input string name, input logic exp_f,
                               input logic exp_buz, input logic [6:0] exp_led);
        checks++;
        if (bus.F !== exp_f) begin
            errors++;
            $display("[TB] FAIL %s.F: got %b want %b", name, bus.F, exp_f);
        end
        checks++;
        if (bus.Buzzer !== exp_buz) begin
            errors++;
            $display("[TB] FAIL %s.Buzzer: got %b want %b", name, bus.Buzzer, exp_buz);
        end
        checks++;
        if (bus.LED !== exp_led) begin
            errors++;
            $display("[TB] FAIL %s.LED: got %b want %b", name, bus.LED, exp_led);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(3'b000);
        stepCycle();
        stepCycle();
        rst = 1'b0;
        repeat (5) stepCycle();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;

        vecs[0] = '{3'b000, 50, 1'b0, S0};
        vecs[1] = '{3'b001, 50, 1'b1, S1};
        vecs[2] = '{3'b010, 50, 1'b1, S2};
        vecs[3] = '{3'b011, 50, 1'b0, S3};
        vecs[4] = '{3'b100, 50, 1'b1, S4};
        vecs[5] = '{3'b101, 50, 1'b0, S5};
        vecs[6] = '{3'b110, 50, 1'b0, S6};
        vecs[7] = '{3'b111, 50, 1'b1, S7};

        // Reset state, held and after release
        rst = 1'b1;
        applyStimulus(3'b000);
        stepCycle();
        stepCycle();
        checkOutput("reset_held", 1'b0, 1'b0, S0);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            stepCycle();
            checkOutput("reset_idle", 1'b0, 1'b0, S0);
        end

        // Clean S1 rise: lamp and buzzer on edge 7, beep covers edges 7..14
        applyStimulus(3'b001);
        cyc = 0;
        stepTo(6);
        checkOutput("clean_edge6", 1'b0, 1'b0, S0);
        stepTo(7);
        checkOutput("clean_edge7", 1'b1, 1'b1, S1);
        for (int k = 8; k <= 14; k++) begin
            stepTo(k);
            checkOutput("clean_beep", 1'b1, 1'b1, S1);
        end
        stepTo(15);
        checkOutput("clean_beep_end", 1'b1, 1'b0, S1);

        // 3-cycle S2 glitch is ignored
        stepTo(20);
        for (int k = 0; k < 20; k++) begin
            if (k == 0) applyStimulus(3'b011);
            if (k == 3) applyStimulus(3'b001);
            stepCycle();
            checkOutput("bounce", 1'b1, 1'b0, S1);
        end

        // Auto-off: lamp rose at edge 7, falls at edge 71 with a fresh beep
        stepTo(70);
        checkOutput("autooff_before", 1'b1, 1'b0, S1);
        stepTo(71);
        checkOutput("autooff_fall", 1'b0, 1'b1, S1);
        for (int k = 72; k <= 78; k++) begin
            stepTo(k);
            checkOutput("autooff_beep", 1'b0, 1'b1, S1);
        end
        stepTo(79);
        checkOutput("autooff_beep_end", 1'b0, 1'b0, S1);

        // Next toggle after auto-off starts from a dark lamp
        stepTo(80);
        applyStimulus(3'b011);
        cyc = 0;
        stepTo(6);
        checkOutput("after_off_edge6", 1'b0, 1'b0, S1);
        stepTo(7);
        checkOutput("after_off_edge7", 1'b1, 1'b1, S3);

        // Sweep 000..111: lamp follows switch parity, digit follows code
        doReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].sw);
            repeat (vecs[i].hold) stepCycle();
            checkOutput($sformatf("sweep_%0d", i), vecs[i].exp_f, 1'b0, vecs[i].exp_led);
        end

        // Retrigger: two-bit change 3 cycles into a beep keeps the lamp
        // (parity cancels) and restarts the beep from edge 10 to edge 17
        doReset();
        applyStimulus(3'b001);
        cyc = 0;
        stepTo(3);
        applyStimulus(3'b111);
        stepTo(7);
        checkOutput("retrig_first", 1'b1, 1'b1, S1);
        stepTo(10);
        checkOutput("retrig_second", 1'b1, 1'b1, S7);
        stepTo(15);
        checkOutput("retrig_extended", 1'b1, 1'b1, S7);
        stepTo(17);
        checkOutput("retrig_last", 1'b1, 1'b1, S7);
        stepTo(18);
        checkOutput("retrig_end", 1'b1, 1'b0, S7);

        // Reset mid-beep clears lamp and buzzer before the next edge
        applyStimulus(3'b100);
        stepTo(27);
        checkOutput("pre_reset_beep", 1'b1, 1'b1, S4);
        rst = 1'b1;
        #2;
        checkOutput("reset_midbeep", 1'b0, 1'b0, S0);
        applyStimulus(3'b000);
        stepCycle();
        stepCycle();
        rst = 1'b0;
        repeat (20) stepCycle();
        checkOutput("reset_no_replay", 1'b0, 1'b0, S0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
